// File: rtl/asmi_flash_read_sequencer.sv
// rtl/asmi_flash_read_sequencer.sv - SPI READ burst sequencer over the shared active-serial flash pins
// Define ASMI_FAST_READ_EN to issue FAST READ (0x0B) with an 8-clock dummy phase.
module asmi_flash_read_sequencer #(
    parameter int CLK_DIV       = 2,
    parameter int LEN_W         = 16,
    parameter int GRANT_TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [23:0]      start_addr,
    input  logic [LEN_W-1:0] length,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             asmi_access_request,
    input  logic             asmi_access_granted,
    output logic             flash_dclk,
    output logic             flash_sce,
    output logic             flash_sdo,
    input  logic             flash_data0
);

`ifdef ASMI_FAST_READ_EN
    localparam logic [7:0] READ_CMD = 8'h0B;
`else
    localparam logic [7:0] READ_CMD = 8'h03;
`endif
    localparam int WAIT_W = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_REQ, S_SEL, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DESEL, S_REL
    } state_t;

    state_t             r_state;
    logic [7:0]         r_div;
    logic [4:0]         r_bit;
    logic [31:0]        r_shift;
    logic [7:0]         r_rx;
    logic [LEN_W-1:0]   r_len;
    logic [WAIT_W-1:0]  r_wait;
    logic               r_busy;
    logic               r_done;
    logic               r_error;
    logic [7:0]         r_rd_data;
    logic               r_rd_valid;
    logic               r_req;
    logic               r_dclk;
    logic               r_sce;
    logic               r_sdo;

    logic               w_div_end;
    logic               w_grant_lost;
    logic               w_hold;

    assign w_div_end    = (r_div == 8'(CLK_DIV - 1));
    assign w_grant_lost = !asmi_access_granted &&
                          (r_state inside {S_SEL, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DESEL});
    // A new byte may only begin once the previous one has been taken.
    assign w_hold       = (r_state == S_DATA) && (r_bit == 5'd0) && !r_dclk &&
                          (r_div == 8'd0) && r_rd_valid && !rd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_div      <= 8'd0;
            r_bit      <= 5'd0;
            r_shift    <= 32'd0;
            r_rx       <= 8'd0;
            r_len      <= '0;
            r_wait     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_rd_data  <= 8'd0;
            r_rd_valid <= 1'b0;
            r_req      <= 1'b0;
            r_dclk     <= 1'b0;
            r_sce      <= 1'b1;
            r_sdo      <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            if (r_rd_valid && rd_ready) begin
                r_rd_valid <= 1'b0;
            end
            if (w_grant_lost) begin
                r_state    <= S_IDLE;
                r_sce      <= 1'b1;
                r_dclk     <= 1'b0;
                r_sdo      <= 1'b0;
                r_req      <= 1'b0;
                r_error    <= 1'b1;
                r_busy     <= 1'b0;
                r_rd_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            if (length == '0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_shift <= {READ_CMD, start_addr};
                                r_len   <= length;
                                r_wait  <= '0;
                                r_busy  <= 1'b1;
                                r_req   <= 1'b1;
                                r_state <= S_REQ;
                            end
                        end
                    end
                    S_REQ: begin
                        if (asmi_access_granted) begin
                            r_sce   <= 1'b0;
                            r_div   <= 8'd0;
                            r_state <= S_SEL;
                        end else if (r_wait == WAIT_W'(GRANT_TIMEOUT - 1)) begin
                            r_req   <= 1'b0;
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_wait <= r_wait + WAIT_W'(1);
                        end
                    end
                    S_SEL: begin
                        if (w_div_end) begin
                            r_div   <= 8'd0;
                            r_bit   <= 5'd0;
                            r_sdo   <= r_shift[31];
                            r_shift <= {r_shift[30:0], 1'b0};
                            r_state <= S_CMD;
                        end else begin
                            r_div <= r_div + 8'd1;
                        end
                    end
                    S_CMD, S_ADDR: begin
                        if (w_div_end) begin
                            r_div  <= 8'd0;
                            r_dclk <= ~r_dclk;
                            if (r_dclk) begin
                                r_bit   <= r_bit + 5'd1;
                                r_sdo   <= r_shift[31];
                                r_shift <= {r_shift[30:0], 1'b0};
                                if (r_bit == 5'd7) begin
                                    r_state <= S_ADDR;
                                end
                                if (r_bit == 5'd31) begin
                                    r_bit <= 5'd0;
                                    r_sdo <= 1'b0;
`ifdef ASMI_FAST_READ_EN
                                    r_state <= S_DUMMY;
`else
                                    r_state <= S_DATA;
`endif
                                end
                            end
                        end else begin
                            r_div <= r_div + 8'd1;
                        end
                    end
`ifdef ASMI_FAST_READ_EN
                    S_DUMMY: begin
                        if (w_div_end) begin
                            r_div  <= 8'd0;
                            r_dclk <= ~r_dclk;
                            if (r_dclk) begin
                                r_bit <= r_bit + 5'd1;
                                if (r_bit == 5'd7) begin
                                    r_bit   <= 5'd0;
                                    r_state <= S_DATA;
                                end
                            end
                        end else begin
                            r_div <= r_div + 8'd1;
                        end
                    end
`endif
                    S_DATA: begin
                        if (!w_hold) begin
                            if (w_div_end) begin
                                r_div  <= 8'd0;
                                r_dclk <= ~r_dclk;
                                if (!r_dclk) begin
                                    r_rx <= {r_rx[6:0], flash_data0};
                                    if (r_bit == 5'd7) begin
                                        r_rd_data  <= {r_rx[6:0], flash_data0};
                                        r_rd_valid <= 1'b1;
                                    end
                                end else begin
                                    r_bit <= r_bit + 5'd1;
                                    if (r_bit == 5'd7) begin
                                        r_bit <= 5'd0;
                                        r_len <= r_len - LEN_W'(1);
                                        if (r_len == LEN_W'(1)) begin
                                            r_sce   <= 1'b1;
                                            r_state <= S_DESEL;
                                        end
                                    end
                                end
                            end else begin
                                r_div <= r_div + 8'd1;
                            end
                        end
                    end
                    S_DESEL: begin
                        if (w_div_end) begin
                            r_div   <= 8'd0;
                            r_state <= S_REL;
                        end else begin
                            r_div <= r_div + 8'd1;
                        end
                    end
                    S_REL: begin
                        r_req   <= 1'b0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign busy                = r_busy;
    assign done                = r_done;
    assign error               = r_error;
    assign rd_data             = r_rd_data;
    assign rd_valid            = r_rd_valid;
    assign asmi_access_request = r_req;
    assign flash_dclk          = r_dclk;
    assign flash_sce           = r_sce;
    assign flash_sdo           = r_sdo;

endmodule

// File: tb/tb_asmi_flash_read_sequencer.sv
// tb/tb_asmi_flash_read_sequencer.sv - directed self-checking bench for asmi_flash_read_sequencer
module tb_asmi_flash_read_sequencer;
    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [23:0]      start_addr;
    logic [LEN_W-1:0] length;
    logic             busy;
    logic             done;
    logic             error;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic             rd_ready;
    logic             asmi_access_request;
    logic             asmi_access_granted;
    logic             flash_dclk;
    logic             flash_sce;
    logic             flash_sdo;
    logic             flash_data0;

    int checks = 0;
    int errors = 0;

    asmi_flash_read_sequencer #(
        .CLK_DIV(2), .LEN_W(LEN_W), .GRANT_TIMEOUT(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .length(length), .busy(busy), .done(done), .error(error),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .asmi_access_request(asmi_access_request),
        .asmi_access_granted(asmi_access_granted),
        .flash_dclk(flash_dclk), .flash_sce(flash_sce), .flash_sdo(flash_sdo),
        .flash_data0(flash_data0)
    );

    always #5 clk = ~clk;

    // Flash model: counts dclk rises per selection, captures the command word, serves data bytes.
    logic [7:0]  m_data [0:3];
    logic [31:0] m_cmd = 32'd0;
    int          m_nbits = 0;
    int          m_idx;
    logic        m_dclk_q = 1'b0;
    logic        m_sce_q = 1'b1;
    logic        m_req_q = 1'b0;
    int          dclk_rises = 0;
    int          sce_falls = 0;
    int          req_rises = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    logic [7:0]  rx_mem [0:31];
    int          rx_cnt = 0;

    always_comb begin
        m_idx = m_nbits - 32;
        flash_data0 = 1'b0;
        if (m_nbits >= 32 && m_nbits < 64) begin
            flash_data0 = m_data[m_idx / 8][7 - (m_idx % 8)];
        end
    end

    always @(negedge clk) begin
        m_dclk_q <= flash_dclk;
        m_sce_q  <= flash_sce;
        m_req_q  <= asmi_access_request;
        if (asmi_access_request && !m_req_q) req_rises <= req_rises + 1;
        if (!flash_sce && m_sce_q) sce_falls <= sce_falls + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (error) err_cnt <= err_cnt + 1;
        if (flash_dclk && !m_dclk_q) dclk_rises <= dclk_rises + 1;
        if (flash_sce) begin
            m_nbits <= 0;
        end else if (flash_dclk && !m_dclk_q) begin
            if (m_nbits < 32) m_cmd <= {m_cmd[30:0], flash_sdo};
            m_nbits <= m_nbits + 1;
        end
    end

    always @(posedge clk) begin
        if (rd_valid && rd_ready) begin
            rx_mem[rx_cnt % 32] <= rd_data;
            rx_cnt <= rx_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [23:0] a, input logic [LEN_W-1:0] n);
        @(negedge clk);
        start = 1'b1;
        start_addr = a;
        length = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic set_data(input logic [31:0] w);
        m_data[0] = w[31:24];
        m_data[1] = w[23:16];
        m_data[2] = w[15:8];
        m_data[3] = w[7:0];
    endtask

    function automatic logic [15:0] out_vec();
        return {busy, done, error, rd_valid, asmi_access_request, flash_dclk, flash_sce, flash_sdo, rd_data};
    endfunction

    bit ok;
    int b_rise, b_rx, b_done, b_err, b_req, b_sce;

    initial begin
        rst_n = 1'b0; start = 1'b0; start_addr = '0; length = '0;
        rd_ready = 1'b1; asmi_access_granted = 1'b0;
        set_data(32'h0);
        repeat (3) @(negedge clk);
        check("reset_outputs", out_vec(), 16'h0200);
        rst_n = 1'b1;
        @(negedge clk);

        // Normal 4-byte read, grant arrives 5 cycles after start.
        set_data(32'hA53CFF00);
        b_rise = dclk_rises; b_rx = rx_cnt; b_done = done_cnt; b_err = err_cnt;
        do_start(24'h012345, 16'd4);
        check("t1_busy_req", {busy, asmi_access_request, flash_sce}, 3'b111);
        repeat (4) @(negedge clk);
        asmi_access_granted = 1'b1;
        wait_done(2000, ok);
        check("t1_done_seen", ok, 1'b1);
        check("t1_done_busy_req", {done, busy, asmi_access_request, flash_sce}, 4'b1001);
        asmi_access_granted = 1'b0;
        repeat (3) @(negedge clk);
        check("t1_cmd_word", m_cmd, 32'h03012345);
        check("t1_rx_count", rx_cnt - b_rx, 4);
        check("t1_rx_bytes", {rx_mem[b_rx], rx_mem[b_rx+1], rx_mem[b_rx+2], rx_mem[b_rx+3]}, 32'hA53CFF00);
        check("t1_done_pulses", done_cnt - b_done, 1);
        check("t1_dclk_rises", dclk_rises - b_rise, 64);
        check("t1_no_error", err_cnt - b_err, 0);

        // Zero-length start completes at once without touching the bus.
        b_rise = dclk_rises; b_req = req_rises; b_sce = sce_falls;
        do_start(24'h000100, 16'd0);
        check("t2_done_busy", {done, busy}, 2'b10);
        @(negedge clk);
        check("t2_done_cleared", {done, busy, asmi_access_request}, 3'b000);
        repeat (3) @(negedge clk);
        check("t2_no_bus_activity", {32'(req_rises - b_req), 32'(sce_falls - b_sce)}, 64'd0);
        check("t2_no_dclk", dclk_rises - b_rise, 0);

        // Grant never arrives: error on the 17th cycle after start.
        b_rise = dclk_rises; b_sce = sce_falls; b_err = err_cnt;
        do_start(24'h000200, 16'd2);
        repeat (15) @(negedge clk);
        check("t3_pre_timeout", {error, busy, asmi_access_request}, 3'b011);
        @(negedge clk);
        check("t3_timeout", {error, busy, asmi_access_request}, 3'b100);
        repeat (2) @(negedge clk);
        check("t3_no_select", {32'(dclk_rises - b_rise), 32'(sce_falls - b_sce)}, 64'd0);
        check("t3_err_pulses", err_cnt - b_err, 1);

        // Backpressure: consumer stalls for 50 cycles after the first byte.
        set_data(32'h11223300);
        asmi_access_granted = 1'b1;
        rd_ready = 1'b0;
        b_rise = dclk_rises; b_rx = rx_cnt;
        do_start(24'h000300, 16'd3);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (rd_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("t4_first_valid", ok, 1'b1);
        repeat (5) @(negedge clk);
        b_done = dclk_rises;
        repeat (45) @(negedge clk);
        check("t4_frozen", {dclk_rises - b_done, 32'(flash_dclk), 32'(flash_sce)}, 96'd0);
        check("t4_held_byte", {rd_valid, rd_data}, 9'h111);
        rd_ready = 1'b1;
        wait_done(1000, ok);
        check("t4_done_seen", ok, 1'b1);
        @(negedge clk);
        check("t4_rx_bytes", {rx_mem[b_rx], rx_mem[b_rx+1], rx_mem[b_rx+2], 8'(rx_cnt - b_rx)}, 32'h11223303);
        check("t4_dclk_rises", dclk_rises - b_rise, 56);

        // Grant withdrawn during the second byte.
        set_data(32'h6699AA55);
        b_rx = rx_cnt; b_err = err_cnt; b_done = done_cnt;
        do_start(24'h000400, 16'd4);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (rx_cnt - b_rx >= 1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("t5_first_byte", ok, 1'b1);
        repeat (6) @(negedge clk);
        check("t5_mid_byte", {busy, flash_sce}, 2'b10);
        asmi_access_granted = 1'b0;
        @(negedge clk);
        check("t5_abort", {flash_sce, flash_dclk, asmi_access_request, error, busy, rd_valid}, 6'b100100);
        repeat (40) @(negedge clk);
        check("t5_bytes_delivered", {rx_mem[b_rx], 8'(rx_cnt - b_rx)}, 16'h6601);
        check("t5_pulses", {32'(err_cnt - b_err), 32'(done_cnt - b_done)}, {32'd1, 32'd0});

        // Asynchronous reset in the middle of the address phase, then a fresh read.
        asmi_access_granted = 1'b1;
        do_start(24'hABCDEF, 16'd2);
        repeat (44) @(negedge clk);
        check("t6_in_addr", {busy, flash_sce}, 2'b10);
        #1 rst_n = 1'b0;
        #1 check("t6_async_reset", out_vec(), 16'h0200);
        @(negedge clk);
        rst_n = 1'b1;
        set_data(32'h5AC30000);
        b_rx = rx_cnt;
        do_start(24'h000010, 16'd2);
        wait_done(1000, ok);
        check("t6_done_seen", ok, 1'b1);
        @(negedge clk);
        check("t6_cmd_word", m_cmd, 32'h03000010);
        check("t6_rx_bytes", {rx_mem[b_rx], rx_mem[b_rx+1], 8'(rx_cnt - b_rx)}, 24'h5AC302);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/asmi_flash_read_sequencer.md
Name: asmi_flash_read_sequencer

Overview:
Sequences single-bit SPI READ bursts from the configuration flash over the shared active-serial pins. It owns the access request/grant handshake with the serial flash loader. It streams bytes to user logic over a valid/ready interface. It sits between user-side boot/readback logic and the shared flash-loader access port (request, grant, dclk, sce, sdo, data0).

Parameters:
CLK_DIV, 2, clk cycles per dclk half-period; legal 1..255
LEN_W, 16, width of the byte-count input
GRANT_TIMEOUT, 1024, clk cycles to wait for grant before error; legal >= 1

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; accepted only when busy=0
start_addr  input  24  flash byte address, sampled on accepted start
length  input  LEN_W  bytes to read, sampled on accepted start
busy  output  1  high from accepted start until done/error pulse
done  output  1  one-cycle pulse on successful completion
error  output  1  one-cycle pulse on grant timeout or grant loss
rd_data  output  8  received byte, MSB first on wire
rd_valid  output  1  rd_data valid; held until rd_ready
rd_ready  input  1  consumer accepts rd_data when rd_valid & rd_ready
asmi_access_request  output  1  request for the shared flash pins
asmi_access_granted  input  1  grant from the flash-loader arbiter
flash_dclk  output  1  SPI clock, idle low (mode 0)
flash_sce  output  1  chip select, active low, idle high
flash_sdo  output  1  serial data to flash
flash_data0  input  1  serial data from flash

Behaviour:
- Reset: busy=0, done=0, error=0, rd_valid=0, rd_data=0, asmi_access_request=0, flash_dclk=0, flash_sce=1, flash_sdo=0. State = IDLE. Asserting rst_n low mid-operation forces these values immediately. No flash cycle is completed.
- States: IDLE -> REQ -> SEL -> CMD -> ADDR -> DATA -> DESEL -> REL -> IDLE.
- IDLE: a start with length=0 gives a done pulse on the next cycle. No request is raised and busy stays 0. A start with length!=0 latches address and length, sets busy, and enters REQ.
- REQ: asmi_access_request=1. A wait counter runs. When asmi_access_granted=1, go to SEL. If GRANT_TIMEOUT cycles elapse with no grant: drop the request, pulse error, clear busy, return to IDLE.
- SEL: flash_sce=0 for CLK_DIV cycles with dclk low, then CMD.
- CMD: shift 8'h03 MSB first. ADDR: shift start_addr[23:0] MSB first.
- Bit timing: sdo is updated while dclk is low; dclk rises after CLK_DIV cycles; dclk falls CLK_DIV cycles later. One bit takes 2*CLK_DIV clk cycles.
- DATA: flash_data0 is sampled on the clk edge where dclk goes 0->1. After 8 bits the byte loads into rd_data and rd_valid is set.
- Backpressure: if rd_valid is still 1 when the next byte would start, hold dclk low and sce low until the handshake completes. No bits are lost or duplicated.
- After `length` bytes: DESEL drives sce=1 for CLK_DIV cycles. REL then drops the request, pulses done, clears busy, and returns to IDLE. done is asserted in the same cycle busy falls.
- A byte counter decrements per byte. Reads wrap at address 24'hFFFFFF -> 0; this is the flash's own behaviour, and the block adds no special handling.
- Grant loss: if asmi_access_granted falls in SEL..DESEL, then within 1 cycle sce=1, dclk=0, request=0, error pulses, busy clears, and any undelivered byte is dropped (rd_valid=0).
- start while busy=1 is ignored.
- The request is never raised while busy=0.

Optional Feature:
ASMI_FAST_READ_EN
- Defined: the command is 8'h0B (FAST READ). A DUMMY state inserts 8 dclk cycles with sdo=0 between ADDR and DATA.
- Undefined: the command is 8'h03 and there is no DUMMY state.
- Timing and handshakes are otherwise identical.

Test Plan:
- CLK_DIV=2, start addr=24'h012345 len=4, grant after 5 cycles, flash model returns A5,3C,FF,00: wire shows 03 01 23 45; rd_data sequence is A5,3C,FF,00; one done pulse; 32+32 dclk rising edges; request low after done.
- len=0 start: done one cycle later; request, sce, dclk never toggle; busy stays 0.
- GRANT_TIMEOUT=16, grant held low: error pulses on cycle 17 after start; request deasserts; no dclk edges.
- rd_ready low for 50 cycles after first byte (len=3): dclk frozen low, sce low; after ready, bytes 2 and 3 arrive intact and in order.
- Grant dropped during byte 2 of len=4: next cycle sce=1 and request=0; error pulses; exactly 1 byte was delivered.
- rst_n pulsed low mid-ADDR: all outputs take their reset values asynchronously. A new start then completes a normal 2-byte read.
